// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
//   Sequences one CPU test run and watches how it ends. It holds the CPU in
//   reset while idle, releases it after a fixed number of reset cycles, and
//   then counts run cycles and retired instructions until the CPU halts, the
//   run times out, or the program counter stops moving. Every output comes
//   straight from a flop.
//
// Parameters
//   RST_CYCLES  - cycles the CPU reset is held after start (>= 1)
//   PC_W        - width of the monitored program counter
//   CNT_W       - width of the cycle and retire counters
//   TIMEOUT     - maximum number of RUN cycles (>= 1, < 2^CNT_W)
//   STALL_LIMIT - consecutive unchanged-pc RUN cycles treated as a hang (>= 1)
//
// Ports
//   clk_in       in   single clock, rising edge
//   rst          in   synchronous active-high reset, beats start/abort
//   start        in   single-cycle run request (IDLE or DONE only)
//   abort        in   cancel the run (RESET or RUN only)
//   cpu_halt     in   CPU reports it has halted
//   retire       in   instruction-retired strobe
//   pc           in   CPU program counter
//   cpu_rst      out  reset driven to the CPU (low only in RUN)
//   running      out  high while in RUN
//   done         out  high while in DONE
//   status       out  00 none, 01 halt, 10 timeout, 11 stall
//   cycle_count  out  RUN cycles elapsed (saturating)
//   retire_count out  retire strobes seen in RUN (saturating)
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
  parameter int RST_CYCLES  = 4,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cpu_halt,
  input  logic             retire,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_STALL   = 2'b11;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [SW-1:0]    STALL_V   = SW'(STALL_LIMIT);

  state_t           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [1:0]       status_q, status_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  // Candidate RUN-cycle updates, used by the terminating-event checks so that
  // timeout and stall are judged on the values the counters are about to take.
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] retire_inc;
  logic [SW-1:0]    stall_inc;

  always_comb begin
    cycle_inc  = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
    retire_inc = retire_q;
    if (retire && (retire_q != '1)) begin
      retire_inc = retire_q + CNT_W'(1);
    end
    // The run ends as soon as this reaches STALL_LIMIT, so it cannot wrap.
    stall_inc = (pc == pc_q) ? stall_q + SW'(1) : '0;
  end

  // State register (all flops, including the registered outputs).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      stall_q   <= '0;
      pc_q      <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
      status_q  <= ST_NONE;
      cpu_rst_q <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      stall_q   <= stall_d;
      pc_q      <= pc_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      status_q  <= status_d;
      cpu_rst_q <= cpu_rst_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stall_d   = stall_q;
    pc_d      = pc;  // previous-pc copy follows pc in every state
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    status_d  = status_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          stall_d   = '0;
          cycle_d   = '0;
          retire_d  = '0;
          status_d  = ST_NONE;
        end
      end

      S_RESET: begin
        if (abort) begin
          state_d  = S_IDLE;
          status_d = ST_NONE;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      S_RUN: begin
        if (abort) begin
          // Counters keep the values they had going into this cycle.
          state_d  = S_IDLE;
          status_d = ST_NONE;
        end else begin
          cycle_d  = cycle_inc;
          retire_d = retire_inc;
          stall_d  = stall_inc;
          if (cpu_halt) begin
            state_d  = S_DONE;
            status_d = ST_HALT;
          end else if (cycle_inc == TIMEOUT_V) begin
            state_d  = S_DONE;
            status_d = ST_TIMEOUT;
          end else if (stall_inc == STALL_V) begin
            state_d  = S_DONE;
            status_d = ST_STALL;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with
  // the state they describe (cpu_rst falls on the same edge running rises).
  always_comb begin
    cpu_rst_d = (state_d != S_RUN);
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  assign cpu_rst      = cpu_rst_q;
  assign running      = running_q;
  assign done         = done_q;
  assign status       = status_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
//   Self-checking bench for cpu_run_monitor (RST_CYCLES=4, TIMEOUT=100,
//   STALL_LIMIT=8). Each run is described by per-RUN-cycle stimulus tables;
//   a run-level reference model scans those tables to predict how and when
//   the run ends, and the scenario tasks compare the DUT against it (or
//   against fixed expected numbers for the directed cases).
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

  localparam int RST_CYCLES  = 4;
  localparam int PC_W        = 32;
  localparam int CNT_W       = 32;
  localparam int TIMEOUT     = 100;
  localparam int STALL_LIMIT = 8;
  localparam int MAXC        = TIMEOUT + 4;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cpu_halt = 1'b0;
  logic             retire = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             cpu_rst;
  logic             running;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  cpu_run_monitor #(
    .RST_CYCLES (RST_CYCLES),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cpu_halt    (cpu_halt),
    .retire      (retire),
    .pc          (pc),
    .cpu_rst     (cpu_rst),
    .running     (running),
    .done        (done),
    .status      (status),
    .cycle_count (cycle_count),
    .retire_count(retire_count)
  );

  // Stimulus tables: index 0 is the pc held during RESET, 1..MAXC are RUN cycles.
  logic [PC_W-1:0] s_pc [0:MAXC];
  bit s_ret   [0:MAXC];
  bit s_halt  [0:MAXC];
  bit s_abort [0:MAXC];
  bit s_start [0:MAXC];
  bit s_rst   [0:MAXC];

  // Observed end-of-run values.
  logic [1:0]       o_status;
  logic [CNT_W-1:0] o_cycles;
  logic [CNT_W-1:0] o_retires;
  logic             o_done, o_running, o_cpu_rst;
  int               o_len;
  int               o_seq_err;

  // Expected end-of-run values.
  int e_status, e_cycles, e_retires, e_len;
  bit e_done;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_stim(input logic [PC_W-1:0] base);
    for (int k = 0; k <= MAXC; k++) begin
      s_pc[k]    = base + PC_W'(4 * k);
      s_ret[k]   = 1'b0;
      s_halt[k]  = 1'b0;
      s_abort[k] = 1'b0;
      s_start[k] = 1'b0;
      s_rst[k]   = 1'b0;
    end
  endtask

  // Length of the unbroken run of identical pcs ending at RUN cycle k.
  function automatic int stall_len(input int k);
    int n = 0;
    for (int j = k; j >= 1; j--) begin
      if (s_pc[j] != s_pc[j-1]) break;
      n++;
    end
    return n;
  endfunction

  // Run-level reference: walk the RUN cycles and find the first ending event.
  task automatic model_run();
    int ret = 0;
    int st;
    e_status = 0; e_cycles = 0; e_retires = 0; e_done = 1'b0; e_len = MAXC;
    for (int k = 1; k <= MAXC; k++) begin
      if (s_rst[k]) begin
        e_status = 0; e_cycles = 0; e_retires = 0; e_done = 1'b0; e_len = k;
        return;
      end
      if (s_abort[k]) begin
        e_status = 0; e_cycles = k - 1; e_retires = ret; e_done = 1'b0; e_len = k;
        return;
      end
      ret += int'(s_ret[k]);
      st = 0;
      if (s_halt[k])                          st = 1;
      else if (k == TIMEOUT)                  st = 2;
      else if (stall_len(k) == STALL_LIMIT)   st = 3;
      if (st != 0) begin
        e_status = st; e_cycles = k; e_retires = ret; e_done = 1'b1; e_len = k;
        return;
      end
    end
  endtask

  // Pulse start, walk RESET and RUN from the tables, capture the end state.
  // o_seq_err counts cycles where the reset/run handshake looked wrong.
  task automatic drive_run();
    o_seq_err = 0;
    rst = 1'b0; abort = 1'b0; cpu_halt = 1'b0; retire = 1'b0;
    start = 1'b1; pc = s_pc[0];
    tick();
    start = 1'b0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      if (cpu_rst !== 1'b1 || running !== 1'b0 || done !== 1'b0 ||
          cycle_count !== '0 || retire_count !== '0 || status !== 2'b00)
        o_seq_err++;
      tick();
    end
    if (running !== 1'b1 || cpu_rst !== 1'b0) o_seq_err++;
    o_len = 0;
    for (int k = 1; k <= MAXC; k++) begin
      pc = s_pc[k]; retire = s_ret[k]; cpu_halt = s_halt[k];
      abort = s_abort[k]; start = s_start[k]; rst = s_rst[k];
      tick();
      o_len = k;
      if (running !== 1'b1) break;
      if (cpu_rst !== 1'b0 || cycle_count !== CNT_W'(k)) o_seq_err++;
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; cpu_halt = 1'b0; retire = 1'b0;
    o_status = status; o_cycles = cycle_count; o_retires = retire_count;
    o_done = done; o_running = running; o_cpu_rst = cpu_rst;
    $display("run: status=%0d cycles=%0d retires=%0d done=%0d len=%0d",
             o_status, o_cycles, o_retires, o_done, o_len);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b expected 0", running); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (status !== 2'b00) begin n_err++; $display("FAIL reset_status: got %0d expected 0", status); end
    n_vec++; if (cycle_count !== '0) begin n_err++; $display("FAIL reset_cycles: got %0d expected 0", cycle_count); end
    n_vec++; if (retire_count !== '0) begin n_err++; $display("FAIL reset_retires: got %0d expected 0", retire_count); end
    // rst wins over a simultaneous start: no run may begin.
    start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < RST_CYCLES + 2; i++) tick();
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_beats_start: got running=%b expected 0", running); end
    $display("reset: cpu_rst=%b running=%b done=%b", cpu_rst, running, done);
  endtask

  task automatic test_startup();
    clear_stim(32'h0000_1000);
    s_halt[3] = 1'b1;
    drive_run();
    n_vec++; if (o_seq_err != 0) begin n_err++; $display("FAIL startup_sequence: got %0d bad cycles expected 0", o_seq_err); end
    n_vec++; if (o_cycles !== CNT_W'(3)) begin n_err++; $display("FAIL startup_cycles: got %0d expected 3", o_cycles); end
  endtask

  task automatic test_halt();
    clear_stim(32'h0000_2000);
    for (int k = 1; k <= MAXC; k++) s_ret[k] = (k % 2) == 1;
    s_halt[10] = 1'b1;
    drive_run();
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL halt_done: got %b expected 1", o_done); end
    n_vec++; if (o_status !== 2'b01) begin n_err++; $display("FAIL halt_status: got %0d expected 1", o_status); end
    n_vec++; if (o_cycles !== CNT_W'(10)) begin n_err++; $display("FAIL halt_cycles: got %0d expected 10", o_cycles); end
    n_vec++; if (o_retires !== CNT_W'(5)) begin n_err++; $display("FAIL halt_retires: got %0d expected 5", o_retires); end
    n_vec++; if (o_seq_err != 0) begin n_err++; $display("FAIL halt_sequence: got %0d bad cycles expected 0", o_seq_err); end
  endtask

  task automatic test_timeout();
    clear_stim(32'h0000_3000);
    for (int k = 1; k <= MAXC; k++) s_ret[k] = $urandom_range(1) == 1;
    model_run();
    drive_run();
    n_vec++; if (o_status !== 2'b10) begin n_err++; $display("FAIL timeout_status: got %0d expected 2", o_status); end
    n_vec++; if (o_cycles !== CNT_W'(100)) begin n_err++; $display("FAIL timeout_cycles: got %0d expected 100", o_cycles); end
    n_vec++; if (o_cpu_rst !== 1'b1) begin n_err++; $display("FAIL timeout_cpu_rst: got %b expected 1", o_cpu_rst); end
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL timeout_done: got %b expected 1", o_done); end
    n_vec++; if (o_retires !== CNT_W'(e_retires)) begin n_err++; $display("FAIL timeout_retires: got %0d expected %0d", o_retires, e_retires); end
  endtask

  task automatic test_stall();
    clear_stim(32'h0000_4000);
    for (int k = 0; k <= MAXC; k++) s_pc[k] = 32'h0000_4000;
    drive_run();
    n_vec++; if (o_status !== 2'b11) begin n_err++; $display("FAIL stall_status: got %0d expected 3", o_status); end
    n_vec++; if (o_cycles !== CNT_W'(8)) begin n_err++; $display("FAIL stall_cycles: got %0d expected 8", o_cycles); end
    n_vec++; if (o_len != 8) begin n_err++; $display("FAIL stall_run_length: got %0d expected 8", o_len); end
  endtask

  task automatic test_coincide();
    // Halt on the timeout cycle: halt wins.
    clear_stim(32'h0000_5000);
    s_halt[TIMEOUT] = 1'b1;
    drive_run();
    n_vec++; if (o_status !== 2'b01) begin n_err++; $display("FAIL halt_vs_timeout_status: got %0d expected 1", o_status); end
    n_vec++; if (o_cycles !== CNT_W'(100)) begin n_err++; $display("FAIL halt_vs_timeout_cycles: got %0d expected 100", o_cycles); end
    // Stall reaches its limit on the timeout cycle: timeout wins.
    clear_stim(32'h0000_5800);
    for (int k = TIMEOUT - STALL_LIMIT; k <= MAXC; k++) s_pc[k] = s_pc[TIMEOUT - STALL_LIMIT];
    drive_run();
    n_vec++; if (o_status !== 2'b10) begin n_err++; $display("FAIL timeout_vs_stall_status: got %0d expected 2", o_status); end
    // Abort together with halt: abort wins, counters hold.
    clear_stim(32'h0000_6000);
    for (int k = 1; k <= MAXC; k++) s_ret[k] = 1'b1;
    s_halt[20] = 1'b1; s_abort[20] = 1'b1;
    drive_run();
    n_vec++; if (o_status !== 2'b00) begin n_err++; $display("FAIL abort_status: got %0d expected 0", o_status); end
    n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", o_done); end
    n_vec++; if (o_running !== 1'b0) begin n_err++; $display("FAIL abort_running: got %b expected 0", o_running); end
    n_vec++; if (o_cycles !== CNT_W'(19)) begin n_err++; $display("FAIL abort_cycles: got %0d expected 19", o_cycles); end
    n_vec++; if (o_retires !== CNT_W'(19)) begin n_err++; $display("FAIL abort_retires: got %0d expected 19", o_retires); end
    n_vec++; if (o_cpu_rst !== 1'b1) begin n_err++; $display("FAIL abort_cpu_rst: got %b expected 1", o_cpu_rst); end
  endtask

  task automatic test_rst_midrun();
    clear_stim(32'h0000_7000);
    for (int k = 1; k <= MAXC; k++) s_ret[k] = 1'b1;
    s_rst[50] = 1'b1;
    drive_run();
    n_vec++; if (o_len != 50) begin n_err++; $display("FAIL rst_run_length: got %0d expected 50", o_len); end
    n_vec++; if (o_cpu_rst !== 1'b1 || o_running !== 1'b0 || o_done !== 1'b0)
      begin n_err++; $display("FAIL rst_flags: got cpu_rst=%b running=%b done=%b expected 1/0/0", o_cpu_rst, o_running, o_done); end
    n_vec++; if (o_status !== 2'b00) begin n_err++; $display("FAIL rst_status: got %0d expected 0", o_status); end
    n_vec++; if (o_cycles !== '0 || o_retires !== '0)
      begin n_err++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", o_cycles, o_retires); end
    clear_stim(32'h0000_7800);
    for (int k = 1; k <= MAXC; k++) s_ret[k] = 1'b1;
    s_halt[5] = 1'b1;
    drive_run();
    n_vec++; if (o_cycles !== CNT_W'(5)) begin n_err++; $display("FAIL rst_rerun_cycles: got %0d expected 5", o_cycles); end
    n_vec++; if (o_retires !== CNT_W'(5)) begin n_err++; $display("FAIL rst_rerun_retires: got %0d expected 5", o_retires); end
    n_vec++; if (o_seq_err != 0) begin n_err++; $display("FAIL rst_rerun_sequence: got %0d bad cycles expected 0", o_seq_err); end
  endtask

  task automatic test_back_to_back();
    clear_stim(32'h0000_8000);
    for (int k = 1; k <= MAXC; k++) s_ret[k] = 1'b1;
    s_halt[12] = 1'b1;
    s_start[4] = 1'b1;  // start inside RUN must be ignored
    drive_run();
    n_vec++; if (o_cycles !== CNT_W'(12)) begin n_err++; $display("FAIL start_in_run_cycles: got %0d expected 12", o_cycles); end
    // abort in DONE is ignored and DONE holds its results.
    abort = 1'b1; retire = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick();
    retire = 1'b0;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL done_hold: got %b expected 1", done); end
    n_vec++; if (status !== 2'b01) begin n_err++; $display("FAIL done_status_hold: got %0d expected 1", status); end
    n_vec++; if (cycle_count !== CNT_W'(12) || retire_count !== CNT_W'(12))
      begin n_err++; $display("FAIL done_counters_hold: got %0d/%0d expected 12/12", cycle_count, retire_count); end
    // Restart straight from DONE; RESET must show cleared counters.
    clear_stim(32'h0000_9000);
    s_halt[2] = 1'b1;
    drive_run();
    n_vec++; if (o_seq_err != 0) begin n_err++; $display("FAIL restart_sequence: got %0d bad cycles expected 0", o_seq_err); end
    n_vec++; if (o_cycles !== CNT_W'(2) || o_retires !== '0)
      begin n_err++; $display("FAIL restart_counters: got %0d/%0d expected 2/0", o_cycles, o_retires); end
  endtask

  task automatic test_random();
    int stay;
    int stay_opts [4] = '{0, 60, 90, 97};
    for (int r = 0; r < 40; r++) begin
      clear_stim($urandom);
      stay = stay_opts[$urandom_range(3)];
      for (int k = 1; k <= MAXC; k++) begin
        s_pc[k]    = ($urandom_range(99) < stay) ? s_pc[k-1] : s_pc[k-1] + PC_W'(4);
        s_ret[k]   = $urandom_range(1) == 1;
        s_halt[k]  = $urandom_range(119) == 0;
        s_abort[k] = $urandom_range(199) == 0;
        s_start[k] = $urandom_range(19) == 0;
      end
      model_run();
      drive_run();
      n_vec++; if (o_status !== 2'(e_status)) begin n_err++; $display("FAIL rand%0d_status: got %0d expected %0d", r, o_status, e_status); end
      n_vec++; if (o_cycles !== CNT_W'(e_cycles)) begin n_err++; $display("FAIL rand%0d_cycles: got %0d expected %0d", r, o_cycles, e_cycles); end
      n_vec++; if (o_retires !== CNT_W'(e_retires)) begin n_err++; $display("FAIL rand%0d_retires: got %0d expected %0d", r, o_retires, e_retires); end
      n_vec++; if (o_done !== e_done) begin n_err++; $display("FAIL rand%0d_done: got %b expected %b", r, o_done, e_done); end
      n_vec++; if (o_len != e_len) begin n_err++; $display("FAIL rand%0d_length: got %0d expected %0d", r, o_len, e_len); end
      n_vec++; if (o_seq_err != 0) begin n_err++; $display("FAIL rand%0d_sequence: got %0d bad cycles expected 0", r, o_seq_err); end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_halt();
    test_timeout();
    test_stall();
    test_coincide();
    test_rst_midrun();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 The module SHALL have parameter RST_CYCLES, default 4: cycles the CPU reset is held after start (>=1).
REQ-002 The module SHALL have parameter PC_W, default 32: width of the monitored program counter.
REQ-003 The module SHALL have parameter CNT_W, default 32: width of the cycle and retire counters.
REQ-004 The module SHALL have parameter TIMEOUT, default 1000: maximum number of RUN cycles (>=1, < 2^CNT_W).
REQ-005 The module SHALL have parameter STALL_LIMIT, default 16: number of consecutive unchanged-pc RUN cycles that constitutes a hang (>=1).
REQ-006 The module SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port start, input, 1 bit: single-cycle run request.
REQ-009 The module SHALL have port abort, input, 1 bit: cancels the current run.
REQ-010 The module SHALL have port cpu_halt, input, 1 bit: the CPU reports that it has halted.
REQ-011 The module SHALL have port retire, input, 1 bit: instruction-retired strobe.
REQ-012 The module SHALL have port pc, input, PC_W bits: the CPU program counter.
REQ-013 The module SHALL have port cpu_rst, output, 1 bit: reset driven to the CPU under test.
REQ-014 The module SHALL have port running, output, 1 bit: high while in RUN.
REQ-015 The module SHALL have port done, output, 1 bit: high while in DONE.
REQ-016 The module SHALL have port status, output, 2 bits: 00 none, 01 halt, 10 timeout, 11 stall.
REQ-017 The module SHALL have port cycle_count, output, CNT_W bits: number of RUN cycles elapsed.
REQ-018 The module SHALL have port retire_count, output, CNT_W bits: number of retire strobes seen in RUN.

Function
REQ-019 The module SHALL implement the states IDLE, RESET, RUN and DONE, with every output registered.
REQ-020 IDLE SHALL drive cpu_rst=1; start SHALL move to RESET and clear cycle_count, retire_count, status and the internal stall counter.
REQ-021 RESET SHALL drive cpu_rst=1 for exactly RST_CYCLES cycles and then enter RUN, with cpu_rst falling on the same edge that running rises.
REQ-022 In RUN, cycle_count SHALL increment by 1 every cycle, and retire_count SHALL increment by 1 on every cycle with retire=1; both counters saturate at all-ones.
REQ-023 A registered copy of pc SHALL update every cycle; in RUN the stall counter increments when pc equals the previous pc and clears to 0 otherwise; the first RUN cycle compares against the pc captured in the last RESET cycle.
REQ-024 RUN SHALL exit to DONE on the first of these terminating events:
  - cpu_halt=1 -> status 01
  - the edge at which cycle_count becomes TIMEOUT -> status 10
  - the edge at which the stall counter becomes STALL_LIMIT -> status 11
REQ-025 When terminating events coincide, the priority SHALL be halt > timeout > stall.
REQ-026 On the edge that enters DONE, the counters SHALL take their final update, including that cycle's retire.
REQ-027 DONE SHALL drive cpu_rst=1 and done=1 and freeze the counters and status; start SHALL restart from RESET with everything cleared.
REQ-028 abort in RESET or RUN SHALL return to IDLE on the next edge with status=00 and counters holding their values; abort beats every terminating event and is ignored in IDLE and DONE.
REQ-029 start SHALL be ignored in RESET and RUN.

Reset
REQ-030 rst=1 SHALL, at any point including mid-run, force IDLE on the next edge with cpu_rst=1, running=0, done=0, status=00, both counters 0, the stall counter 0 and the registered pc 0.
REQ-031 rst SHALL take priority over start and abort in the same cycle.

Verification (RST_CYCLES=4, TIMEOUT=100, STALL_LIMIT=8)
REQ-032 rst held 2 cycles, then start pulsed -> cpu_rst stays high for 4 edges after start, then running=1 and cpu_rst=0 together.
REQ-033 pc incrementing, retire every other cycle, cpu_halt asserted in the 10th RUN cycle -> done=1, status=01, cycle_count=10, retire_count=5.
REQ-034 pc incrementing, no halt -> DONE with status=10 and cycle_count=100; cpu_rst returns to 1.
REQ-035 pc held constant from RUN entry -> DONE with status=11 after 8 RUN cycles and cycle_count=8.
REQ-036 cpu_halt asserted in the cycle where cycle_count goes to 100 -> status=01; abort plus halt in the same RUN cycle -> IDLE with status=00.
REQ-037 rst asserted in RUN cycle 50, then a fresh start -> all outputs at reset values, and the new run counts again from 0.
